// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding request to instruction memory,
// a registered IF/ID slot and a one-entry hold buffer for decode backpressure.
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_address,
  output logic        pc_hold,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        consumed;

  assign imem_addr   = {pc_address[31:2], 2'b00};
  assign imem_req    = (state_q == S_REQ) && !flush;
  assign pc_hold     = !(imem_req && imem_gnt);
  assign consumed    = if_valid_q && id_ready;

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    if_valid_d   = if_valid_q && !consumed;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;

    unique case (state_q)
      S_REQ: begin
        if (flush) begin
          if_valid_d = 1'b0;
        end else if (imem_gnt) begin
          req_pc_d = imem_addr;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // flush outranks everything; a response in the same cycle is dropped
        if (flush) begin
          if_valid_d = 1'b0;
          state_d    = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          if (!if_valid_q || id_ready) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = req_pc_q;
            state_d    = S_REQ;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = req_pc_q;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end else if (id_ready) begin
          if_valid_d = 1'b1;
          if_instr_d = hold_instr_q;
          if_pc_d    = hold_pc_q;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        // the stale response is swallowed here; repeated flush changes nothing
        if (flush) if_valid_d = 1'b0;
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      req_pc_q     <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: basic fetch, backpressure/hold, flush in WAIT
// and with rvalid, PC wrap, and async reset while holding.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_address;
  logic        pc_hold;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int total;
  int bad;

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pc_address  (pc_address),
    .pc_hold     (pc_hold),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_ready    (id_ready),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; pc_address = '0; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    #3;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc",    if_pc,    32'd0);
    chk("rst_pc4",   if_pc_plus4, 32'd4);

    // basic fetch
    step();
    rst = 1'b1; pc_address = 32'h0; imem_gnt = 1'b1; id_ready = 1'b1;
    #1;
    chk("b_req",  {31'd0, imem_req}, 32'd1);
    chk("b_addr", imem_addr, 32'h0);
    chk("b_hold_gnt", {31'd0, pc_hold}, 32'd0);
    step();
    imem_gnt = 1'b0; pc_address = 32'h4;
    imem_rvalid = 1'b1; imem_rdata = 32'h20080005;
    #1;
    chk("b_wait_req",  {31'd0, imem_req}, 32'd0);
    chk("b_wait_hold", {31'd0, pc_hold},  32'd1);
    step();
    imem_rvalid = 1'b0;
    chk("b_valid", {31'd0, if_valid}, 32'd1);
    chk("b_instr", if_instr, 32'h20080005);
    chk("b_pc",    if_pc,    32'h0);
    chk("b_pc4",   if_pc_plus4, 32'h4);
    chk("b_next_req",  {31'd0, imem_req}, 32'd1);
    chk("b_next_addr", imem_addr, 32'h4);

    // backpressure into hold buffer
    id_ready = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; pc_address = 32'h8;
    imem_rvalid = 1'b1; imem_rdata = 32'hAAAA0001;
    step();
    imem_rvalid = 1'b0;
    #1;
    chk("h_req",   {31'd0, imem_req}, 32'd0);
    chk("h_hold",  {31'd0, pc_hold},  32'd1);
    chk("h_valid", {31'd0, if_valid}, 32'd1);
    chk("h_instr_stable", if_instr, 32'h20080005);
    step();
    chk("h_req2",  {31'd0, imem_req}, 32'd0);
    chk("h_instr_stable2", if_instr, 32'h20080005);
    id_ready = 1'b1;
    step();
    chk("h_instr", if_instr, 32'hAAAA0001);
    chk("h_pc",    if_pc,    32'h4);
    chk("h_pc4",   if_pc_plus4, 32'h8);
    chk("h_valid2", {31'd0, if_valid}, 32'd1);
    chk("h_req_after", {31'd0, imem_req}, 32'd1);
    chk("h_addr_after", imem_addr, 32'h8);

    // flush in WAIT without rvalid -> DRAIN
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("f_consumed", {31'd0, if_valid}, 32'd0);
    flush = 1'b1;
    #1;
    chk("f_req_flush", {31'd0, imem_req}, 32'd0);
    step();
    flush = 1'b0; pc_address = 32'h100;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1;
    chk("f_drain_req", {31'd0, imem_req}, 32'd0);
    chk("f_drain_hold", {31'd0, pc_hold}, 32'd1);
    step();
    imem_rvalid = 1'b0;
    chk("f_valid", {31'd0, if_valid}, 32'd0);
    chk("f_instr", if_instr, 32'hAAAA0001);
    chk("f_req",  {31'd0, imem_req}, 32'd1);
    chk("f_addr", imem_addr, 32'h100);

    // flush coincident with rvalid and id_ready
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h11112222; flush = 1'b1; id_ready = 1'b1;
    step();
    imem_rvalid = 1'b0; flush = 1'b0;
    #1;
    chk("c_valid", {31'd0, if_valid}, 32'd0);
    chk("c_instr", if_instr, 32'hAAAA0001);
    chk("c_req",   {31'd0, imem_req}, 32'd1);

    // PC wrap
    pc_address = 32'hFFFFFFFC; imem_gnt = 1'b1;
    #1;
    chk("w_addr", imem_addr, 32'hFFFFFFFC);
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0BADF00D;
    step();
    imem_rvalid = 1'b0;
    chk("w_valid", {31'd0, if_valid}, 32'd1);
    chk("w_instr", if_instr, 32'h0BADF00D);
    chk("w_pc",    if_pc,    32'hFFFFFFFC);
    chk("w_pc4",   if_pc_plus4, 32'h00000000);

    // async reset while in HOLD
    id_ready = 1'b0; pc_address = 32'h200; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h33334444;
    step();
    imem_rvalid = 1'b0;
    #1;
    chk("r_hold_req",  {31'd0, imem_req}, 32'd0);
    chk("r_hold_valid", {31'd0, if_valid}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("r_async_valid", {31'd0, if_valid}, 32'd0);
    chk("r_async_pc",    if_pc,    32'd0);
    chk("r_async_instr", if_instr, 32'd0);
    chk("r_async_pc4",   if_pc_plus4, 32'd4);
    #2;
    rst = 1'b1;
    step();
    chk("r_req_after", {31'd0, imem_req}, 32'd1);
    chk("r_nognt_hold", {31'd0, pc_hold}, 32'd1);
    id_ready = 1'b1;
    step();
    chk("r_hold_empty", {31'd0, if_valid}, 32'd0);
    chk("r_still_req", {31'd0, imem_req}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  in  1  clock; all state updates on posedge.
REQ-002 rst  in  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 pc_address  in  32  current PC value from the PC register.
REQ-004 pc_hold  out  1  1 = PC shall not load next_address this cycle.
REQ-005 flush  in  1  branch/jump redirect; discards all fetched and in-flight instructions.
REQ-006 imem_req  out  1  instruction memory request valid.
REQ-007 imem_addr  out  32  word-aligned request address.
REQ-008 imem_gnt  in  1  memory accepts request this cycle.
REQ-009 imem_rvalid  in  1  read data valid; one response per granted request, in order, ≥1 cycle after grant.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 id_ready  in  1  decode stage accepts the IF/ID entry this cycle.
REQ-012 if_valid  out  1  IF/ID entry valid.
REQ-013 if_instr  out  32  fetched instruction.
REQ-014 if_pc  out  32  address of if_instr.
REQ-015 if_pc_plus4  out  32  if_pc + 4.

Function
REQ-016 FSM states: REQ, WAIT, HOLD, DRAIN; at most one memory request outstanding.
REQ-017 imem_req = 1 only in REQ with flush=0; imem_addr = {pc_address[31:2], 2'b00} (combinational).
REQ-018 pc_hold = 0 only in the cycle imem_req=1 and imem_gnt=1; otherwise 1; the upstream redirect mux overrides pc_hold when flush=1.
REQ-019 REQ: grant -> WAIT, latch req_pc = imem_addr; no grant -> stay, request held stable.
REQ-020 WAIT, rvalid, no flush: if if_valid=0 or id_ready=1 -> load IF/ID (if_instr=imem_rdata, if_pc=req_pc, if_valid=1) and go REQ; else store {imem_rdata, req_pc} in 1-entry hold buffer and go HOLD.
REQ-021 HOLD: id_ready=1 -> move hold buffer into IF/ID (if_valid stays 1), go REQ; else stay; no requests issued.
REQ-022 IF/ID consumed (if_valid=1, id_ready=1) with no new load -> if_valid=0 next cycle; unconsumed entry stays stable.
REQ-023 Fetch-to-output latency: a response with rvalid at edge N appears on if_* after edge N when the slot is free.
REQ-024 if_pc_plus4 = if_pc + 32'd4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-025 flush in REQ or HOLD: clear if_valid and hold buffer, next state REQ.
REQ-026 flush in WAIT: clear if_valid; if rvalid same cycle, discard data and go REQ, else go DRAIN.
REQ-027 DRAIN: no requests; on rvalid discard data, go REQ; further flush in DRAIN has no additional effect.
REQ-028 flush has priority over id_ready and rvalid in the same cycle; discarded data never reaches if_*.

Reset
REQ-029 rst=0: state=REQ, if_valid=0, if_instr=0, if_pc=0, hold buffer empty, req_pc=0; hence if_pc_plus4=4.
REQ-030 rst=0 mid-request (WAIT or DRAIN) abandons the outstanding response; the environment also resets memory, and no stale rvalid is expected after release.
REQ-031 First request issues in the first cycle after rst rises, with flush=0.

Verification
REQ-032 Basic: pc_address=0x0, gnt immediate, rvalid 1 cycle later with 0x20080005, id_ready=1 -> if_valid=1, if_instr=0x20080005, if_pc=0x0, if_pc_plus4=0x4; pc_hold=0 only in the grant cycle.
REQ-033 Backpressure: id_ready=0 with if_valid=1, second response 0xAAAA0001 arrives -> state HOLD, imem_req=0, pc_hold=1; id_ready=1 -> if_instr=0xAAAA0001 next cycle, then a request is issued.
REQ-034 Flush in WAIT without rvalid -> DRAIN; next rvalid data 0xDEADBEEF never appears on if_instr; a request to the redirected pc_address follows.
REQ-035 Flush coincident with rvalid and id_ready -> if_valid=0 next cycle, state REQ, data dropped.
REQ-036 Wrap: pc_address=0xFFFFFFFC fetched -> if_pc=0xFFFFFFFC, if_pc_plus4=0x00000000.
REQ-037 Async reset: drop rst between clock edges while in HOLD -> if_valid=0 immediately, before the next edge; state REQ after release.
